// File: rtl/float_mult_scheduler_pkg.sv
// Shared definitions for the float multiplier scheduler: half-float format and constants.
package float_mult_scheduler_pkg;

   localparam int unsigned FLOAT_W  = 16;
   localparam int unsigned EXP_W    = 5;
   localparam int unsigned MAN_W    = 10;
   localparam int          EXP_BIAS = 15;

   localparam logic [FLOAT_W-1:0] HALF_ONE  = 16'h3C00;
   localparam logic [FLOAT_W-1:0] HALF_ZERO = 16'h0000;
   localparam logic [FLOAT_W-1:0] HALF_INF  = 16'h7C00;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } half_t;

endpackage

// File: rtl/float_mult_scheduler_fmul.sv
// Combinational half-precision multiplier (truncating); zero/subnormal inputs flush to zero.
module floatMult
   import float_mult_scheduler_pkg::*;
(
   input  logic [FLOAT_W-1:0] a,
   input  logic [FLOAT_W-1:0] b,
   output logic [FLOAT_W-1:0] product
);

   half_t              ha, hb;
   logic [21:0]        man_prod;
   logic [MAN_W-1:0]   man_norm;
   logic signed [7:0]  exp_sum;
   logic               sign;

   always_comb begin
      ha       = half_t'(a);
      hb       = half_t'(b);
      sign     = ha.sign ^ hb.sign;
      man_prod = {1'b1, ha.man} * {1'b1, hb.man};
      // Product of two 1.x mantissas lies in [1,4); bit 21 means a one-place renormalise.
      man_norm = man_prod[21] ? man_prod[20:11] : man_prod[19:10];
      exp_sum  = $signed({3'b000, ha.exp}) + $signed({3'b000, hb.exp})
               - 8'sd15 + $signed({7'b0000000, man_prod[21]});
      if (ha.exp == '0 || hb.exp == '0) begin
         product = HALF_ZERO;
      end else if (exp_sum >= 8'sd31) begin
         product = {sign, HALF_INF[FLOAT_W-2:0]};
      end else if (exp_sum <= 8'sd0) begin
         product = HALF_ZERO;
      end else begin
         product = {sign, exp_sum[EXP_W-1:0], man_norm};
      end
   end

endmodule

// File: rtl/float_mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping at N_REQ.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id
);

   logic              found;
   logic [ID_W-1:0]   idx;
   int unsigned       sum;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      sum      = 0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         sum = 32'(ptr) + off;
         if (sum >= N_REQ) sum = sum - N_REQ;
         idx = ID_W'(sum);
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/float_mult_scheduler.sv
// Shares one floatMult among N_REQ requesters: round-robin grant, S1 operand regs, S2 result regs.
module float_mult_scheduler
   import float_mult_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [FLOAT_W*N_REQ-1:0]   req_a,
   input  logic [FLOAT_W*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [FLOAT_W-1:0]         rsp_product,
   output logic [ID_W-1:0]            rsp_id,
   output logic [CNT_W-1:0]           op_count
);

   logic [ID_W-1:0]    rr_ptr, grant_id, s1_id, next_ptr;
   logic [N_REQ-1:0]   grant;
   logic               s1_valid, s1_adv, s2_adv, arb_en, granted;
   logic [FLOAT_W-1:0] s1_a, s1_b, sel_a, sel_b, product;

   always_comb begin
      s2_adv   = !rsp_valid || rsp_ready;
      s1_adv   = !s1_valid || s2_adv;
      // Gating with reset keeps req_ready low for the whole reset cycle.
      arb_en   = s1_adv && !reset;
      granted  = |grant;
      sel_a    = req_a[FLOAT_W*grant_id +: FLOAT_W];
      sel_b    = req_b[FLOAT_W*grant_id +: FLOAT_W];
      next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .en       (arb_en),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = grant;

   floatMult u_fmul (
      .a       (s1_a),
      .b       (s1_b),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr      <= '0;
         s1_valid    <= 1'b0;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_id       <= '0;
         rsp_valid   <= 1'b0;
         rsp_product <= '0;
         rsp_id      <= '0;
         op_count    <= '0;
      end else begin
         if (granted) rr_ptr <= next_ptr;
         if (s1_adv) begin
            s1_valid <= granted;
            if (granted) begin
               s1_a  <= sel_a;
               s1_b  <= sel_b;
               s1_id <= grant_id;
            end
         end
         if (s2_adv) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
               rsp_product <= product;
               rsp_id      <= s1_id;
            end
         end
         if (rsp_valid && rsp_ready) op_count <= op_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_float_mult_scheduler.sv
// Scoreboard bench for float_mult_scheduler: per-requester feeders, response monitor, directed tests.
module tb_float_mult_scheduler;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int CW  = 4;

   logic              clk;
   logic              reset;
   logic [N-1:0]      req_valid, req_ready;
   logic [16*N-1:0]   req_a, req_b;
   logic              rsp_valid, rsp_ready;
   logic [15:0]       rsp_product;
   logic [IDW-1:0]    rsp_id;
   logic [CW-1:0]     op_count;

   float_mult_scheduler #(
      .N_REQ (N),
      .ID_W  (IDW),
      .CNT_W (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_product (rsp_product),
      .rsp_id      (rsp_id),
      .op_count    (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] p;
   } op_t;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [15:0]    p;
   } exp_t;

   op_t          fq [N][$];
   exp_t         sb [$];
   int           hs_id [$];
   int           hs_cyc [$];
   int           hs_total;
   int           cyc;
   int           n_checks;
   int           n_fail;
   logic [N-1:0] acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic add_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
      fq[i].push_back('{a: a, b: b, p: p});
   endtask

   function automatic bit feeders_empty();
      bit e = 1'b1;
      for (int i = 0; i < N; i++) if (fq[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   // Feeder: handshakes are seen at the negedge and complete on the following posedge.
   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      acc       = '0;
      hs_total  = 0;
      cyc       = 0;
      forever begin
         @(negedge clk);
         cyc++;
         acc = '0;
         if (reset) begin
            for (int i = 0; i < N; i++) fq[i].delete();
         end else begin
            for (int i = 0; i < N; i++) begin
               acc[i] = req_valid[i] && req_ready[i];
               if (acc[i]) begin
                  sb.push_back('{id: IDW'(i), p: fq[i][0].p});
                  hs_id.push_back(i);
                  hs_cyc.push_back(cyc);
                  hs_total++;
               end
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i] && fq[i].size() != 0) void'(fq[i].pop_front());
            req_valid[i] = (fq[i].size() != 0);
            if (fq[i].size() != 0) begin
               req_a[16*i +: 16] = fq[i][0].a;
               req_b[16*i +: 16] = fq[i][0].b;
            end
         end
      end
   end

   // Monitor: compares each accepted response, op_count, and stall stability.
   logic        prev_stall;
   logic [15:0] prev_p;
   logic [IDW-1:0] prev_id;
   int          exp_cnt;
   exp_t        e;

   initial begin
      prev_stall = 1'b0;
      prev_p     = '0;
      prev_id    = '0;
      exp_cnt    = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            sb.delete();
            exp_cnt    = 0;
            prev_stall = 1'b0;
         end else begin
            check("op_count", 32'(op_count), exp_cnt % (1 << CW));
            if (prev_stall) begin
               check("stall_valid", 32'(rsp_valid), 1);
               check("stall_product", 32'(rsp_product), 32'(prev_p));
               check("stall_id", 32'(rsp_id), 32'(prev_id));
            end
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: got id %0d product %0h expected none", rsp_id, rsp_product);
               end else begin
                  e = sb.pop_front();
                  check("rsp_product", 32'(rsp_product), 32'(e.p));
                  check("rsp_id", 32'(rsp_id), 32'(e.id));
               end
               exp_cnt++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_p     = rsp_product;
            prev_id    = rsp_id;
         end
      end
   end

   task automatic drain(input string name);
      int k = 0;
      while (k < 300 && !(feeders_empty() && sb.size() == 0 && !rsp_valid)) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_drain: got pending work after %0d cycles expected idle", name, k);
      end
   endtask

   task automatic wait_rsp(input string name, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!rsp_valid && cnt < 50);
      if (!rsp_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got rsp_valid 0 expected 1 within 50 cycles", name);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected $finish");
      $fatal(1, "watchdog expired");
   end

   int lat, base, hs0;

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_rsp_valid", 32'(rsp_valid), 0);
      check("reset_rsp_product", 32'(rsp_product), 0);
      check("reset_rsp_id", 32'(rsp_id), 0);
      check("reset_op_count", 32'(op_count), 0);
      check("reset_req_ready", 32'(req_ready), 0);

      // Single op; queued at this negedge, handshake one cycle later, S2 one cycle after that.
      add_op(0, 16'h4000, 16'h4200, 16'h4600);
      wait_rsp("t1", lat);
      check("t1_latency", lat, 3);
      drain("t1");

      // All four requesters, three ops each; rr_ptr is 1 after the single op on req0.
      @(negedge clk);
      base = hs_id.size();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++)
            add_op(i, 16'h3C00, 16'h4000 + 16'(16'h0100 * (4*r + i)), 16'h4000 + 16'(16'h0100 * (4*r + i)));
      drain("t2");
      check("t2_count", hs_id.size() - base, 12);
      if (hs_id.size() - base == 12)
         for (int k = 0; k < 12; k++) begin
            check("t2_grant_order", hs_id[base+k], (1 + k) % 4);
            check("t2_grant_cycle", hs_cyc[base+k] - hs_cyc[base], k);
         end

      // Stall with all four requesters pending.
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      hs0 = hs_total;
      for (int i = 0; i < N; i++) add_op(i, 16'h3C00, 16'h4800 + 16'(i), 16'h4800 + 16'(i));
      wait_rsp("t3", lat);
      for (int k = 0; k < 5; k++) begin
         check("t3_stall_ready", 32'(req_ready), 0);
         @(negedge clk);
      end
      check("t3_accepted", hs_total - hs0, 2);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      drain("t3");
      check("t3_all_accepted", hs_total - hs0, 4);

      // Arithmetic corner cases.
      @(negedge clk);
      add_op(2, 16'h0DE4, 16'h0000, 16'h0000);
      add_op(3, 16'h3E00, 16'h3E00, 16'h4080);
      add_op(1, 16'hC000, 16'h4200, 16'hC600);
      add_op(0, 16'h3C00, 16'h0000, 16'h0000);
      drain("t4");

      // Reset with both stages full; rr_ptr ends at 3 before reset, so req3 would win without it.
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      add_op(1, 16'h3C00, 16'h4400, 16'h4400);
      add_op(2, 16'h3C00, 16'h4500, 16'h4500);
      wait_rsp("t5", lat);
      @(negedge clk);
      add_op(3, 16'h3C00, 16'h4600, 16'h4600);
      @(posedge clk);
      #1 reset = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_ready_in_reset", 32'(req_ready), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t5_rsp_valid", 32'(rsp_valid), 0);
      check("t5_op_count", 32'(op_count), 0);
      check("t5_req_valid_flushed", 32'(req_valid), 0);
      add_op(3, 16'h3C00, 16'h4700, 16'h4700);
      add_op(0, 16'h3C00, 16'h4100, 16'h4100);
      @(negedge clk);
      check("t5_first_grant", 32'(req_ready), 32'h1);
      drain("t5");

      // op_count wrap: 2 ops above plus 20 here = 22 -> 6 modulo 16.
      @(negedge clk);
      for (int r = 0; r < 5; r++)
         for (int i = 0; i < N; i++)
            add_op(i, 16'h3C00, 16'h3800 + 16'(r*4 + i), 16'h3800 + 16'(r*4 + i));
      drain("t6");
      check("t6_op_count_wrap", 32'(op_count), 6);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
